// File: rtl/packer_stream.sv
// packer_stream
//   Packs IN_WIDTH input words into OUT_WIDTH output words (N = OUT_WIDTH/IN_WIDTH
//   slots) and hands them to the consumer through a two-entry FIFO. A flush emits
//   a partially filled word (unwritten slots zero) together with its valid-word
//   count. Clear synchronously drops the accumulator and the queue.
//
//   Handshakes: a transfer happens on a rising edge where both the enable and
//   the matching ready are high (Unpacked_EnWr/Unpacked_RdyWr,
//   Flush_EnWr/Flush_RdyWr, Packed_EnRd/Packed_RdyRd). All ready outputs are
//   functions of registers only; enables seen while ready is low are ignored.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   Clear             synchronous clear (priority over all other requests)
//   Unpacked_EnWr/RdyWr/DatWr   input word stream
//   Flush_EnWr/RdyWr            flush request for the partial word
//   Packed_RdyRd/EnRd           head-of-queue valid / consumer pop
//   Packed_DatRd/CntRd          head packed word and its valid-word count
//   Busy              accumulator or queue non-empty
module packer_stream #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 128,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = OUT_WIDTH / IN_WIDTH,
  localparam int CW       = $clog2(N + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Clear,
  input  logic                 Unpacked_EnWr,
  output logic                 Unpacked_RdyWr,
  input  logic [IN_WIDTH-1:0]  Unpacked_DatWr,
  input  logic                 Flush_EnWr,
  output logic                 Flush_RdyWr,
  output logic                 Packed_RdyRd,
  input  logic                 Packed_EnRd,
  output logic [OUT_WIDTH-1:0] Packed_DatRd,
  output logic [CW-1:0]        Packed_CntRd,
  output logic                 Busy
);

  if (IN_WIDTH < 1 || (OUT_WIDTH % IN_WIDTH) != 0) begin : g_bad_widths
    $error("packer_stream: OUT_WIDTH must be a positive multiple of IN_WIDTH");
  end

  // accumulator
  logic [OUT_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_dcount;

  // two-entry queue kept as head/tail registers; head feeds the outputs
  logic [1:0]           r_qcnt;
  logic [OUT_WIDTH-1:0] r_head_dat;
  logic [CW-1:0]        r_head_cnt;
  logic [OUT_WIDTH-1:0] r_tail_dat;
  logic [CW-1:0]        r_tail_cnt;

  logic                 w_wr;
  logic                 w_fl;
  logic                 w_pop;
  logic                 w_last;
  logic                 w_push;
  logic [CW-1:0]        w_slot;
  logic [CW-1:0]        w_push_cnt;
  logic [OUT_WIDTH-1:0] w_merged;
  logic                 w_head_new;
  logic                 w_head_tail;
  logic                 w_tail_new;

  assign w_last         = (r_dcount == CW'(N - 1));
  // dcount never exceeds N-1, so "dcount < N-1" is simply "not last slot"
  assign Unpacked_RdyWr = (r_qcnt != 2'd2) | ~w_last;
  assign Flush_RdyWr    = (r_qcnt != 2'd2);
  assign Packed_RdyRd   = (r_qcnt != 2'd0);
  assign Packed_DatRd   = r_head_dat;
  assign Packed_CntRd   = r_head_cnt;
  assign Busy           = (r_dcount != '0) | (r_qcnt != 2'd0);

  assign w_wr  = Unpacked_EnWr & Unpacked_RdyWr;
  assign w_fl  = Flush_EnWr & Flush_RdyWr;
  assign w_pop = Packed_EnRd & Packed_RdyRd;

  // a flush with an empty accumulator and no concurrent write pushes nothing
  assign w_push     = (w_wr & w_last) | (w_fl & ((r_dcount != '0) | w_wr));
  assign w_push_cnt = r_dcount + CW'(w_wr);
  assign w_slot     = MSB_FIRST ? (CW'(N - 1) - r_dcount) : r_dcount;

  // accumulator with the current write merged in; this is what gets pushed
  always_comb begin
    w_merged = r_acc;
    if (w_wr) begin
      for (int k = 0; k < N; k++) begin
        if (w_slot == CW'(k)) begin
          w_merged[k*IN_WIDTH +: IN_WIDTH] = Unpacked_DatWr;
        end
      end
    end
  end

  // queue steering: a push lands in head when head is (or is becoming) free,
  // otherwise in tail; a pop from a full queue shifts tail into head. After the
  // last pop head is left untouched so the outputs keep the last word.
  assign w_head_new  = w_push & ((r_qcnt == 2'd0) | ((r_qcnt == 2'd1) & w_pop));
  assign w_head_tail = w_pop & (r_qcnt == 2'd2);
  assign w_tail_new  = w_push & (((r_qcnt == 2'd1) & ~w_pop) | ((r_qcnt == 2'd2) & w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_dcount   <= '0;
      r_qcnt     <= 2'd0;
      r_head_dat <= '0;
      r_head_cnt <= '0;
      r_tail_dat <= '0;
      r_tail_cnt <= '0;
    end else if (Clear) begin
      r_acc      <= '0;
      r_dcount   <= '0;
      r_qcnt     <= 2'd0;
      r_head_dat <= '0;
      r_head_cnt <= '0;
      r_tail_dat <= '0;
      r_tail_cnt <= '0;
    end else begin
      if (w_push) begin
        r_acc    <= '0;
        r_dcount <= '0;
      end else if (w_wr) begin
        r_acc    <= w_merged;
        r_dcount <= r_dcount + CW'(1);
      end

      if (w_head_new) begin
        r_head_dat <= w_merged;
        r_head_cnt <= w_push_cnt;
      end else if (w_head_tail) begin
        r_head_dat <= r_tail_dat;
        r_head_cnt <= r_tail_cnt;
      end

      if (w_tail_new) begin
        r_tail_dat <= w_merged;
        r_tail_cnt <= w_push_cnt;
      end

      case ({w_push, w_pop})
        2'b10:   r_qcnt <= r_qcnt + 2'd1;
        2'b01:   r_qcnt <= r_qcnt - 2'd1;
        default: r_qcnt <= r_qcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_packer_stream.sv
// Bench for packer_stream: two instances (MSB_FIRST=1 and MSB_FIRST=0, both
// IN=16, OUT=64) share one stimulus stream. A queue-based model tracks the
// pending words and queue depth; packed words are built from the word list
// when a push is due and checked by an independent monitor on each pop.
module tb_packer_stream;
  localparam int IW = 16;
  localparam int OW = 64;
  localparam int N  = OW / IW;
  localparam int CW = $clog2(N + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          clear = 1'b0;
  logic          en_wr = 1'b0;
  logic [IW-1:0] dat_wr = '0;
  logic          fl_en = 1'b0;
  logic          en_rd = 1'b0;

  logic          rdy_wr_m, fl_rdy_m, rdy_rd_m, busy_m;
  logic [OW-1:0] dat_m;
  logic [CW-1:0] cnt_m;
  logic          rdy_wr_l, fl_rdy_l, rdy_rd_l, busy_l;
  logic [OW-1:0] dat_l;
  logic [CW-1:0] cnt_l;

  packer_stream #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .Clear(clear),
    .Unpacked_EnWr(en_wr), .Unpacked_RdyWr(rdy_wr_m), .Unpacked_DatWr(dat_wr),
    .Flush_EnWr(fl_en), .Flush_RdyWr(fl_rdy_m),
    .Packed_RdyRd(rdy_rd_m), .Packed_EnRd(en_rd),
    .Packed_DatRd(dat_m), .Packed_CntRd(cnt_m), .Busy(busy_m)
  );

  packer_stream #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .Clear(clear),
    .Unpacked_EnWr(en_wr), .Unpacked_RdyWr(rdy_wr_l), .Unpacked_DatWr(dat_wr),
    .Flush_EnWr(fl_en), .Flush_RdyWr(fl_rdy_l),
    .Packed_RdyRd(rdy_rd_l), .Packed_EnRd(en_rd),
    .Packed_DatRd(dat_l), .Packed_CntRd(cnt_l), .Busy(busy_l)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q_m[$];
  logic [OW-1:0] exp_q_l[$];
  logic [CW-1:0] exp_q_cnt[$];

  // reference model: words waiting in the accumulator and queue depth
  logic [IW-1:0] m_acc[$];
  int            m_qcnt = 0;
  // expected readiness for the current cycle (state before this cycle's edge)
  bit s_valid = 1'b0;
  bit s_rdy_wr, s_fl_rdy, s_rdy_rd, s_busy;
  // what the outputs must hold once the queue is empty
  logic [OW-1:0] m_last_m = '0;
  logic [OW-1:0] m_last_l = '0;
  logic [CW-1:0] m_last_cnt = '0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack_words(input bit msb);
    logic [OW-1:0] r;
    int slot;
    r = '0;
    for (int k = 0; k < m_acc.size(); k++) begin
      slot = msb ? (N - 1 - k) : k;
      r[slot*IW +: IW] = m_acc[k];
    end
    return r;
  endfunction

  // driver: one call = one clock cycle of stimulus plus model update
  task automatic step(input bit wr, input logic [IW-1:0] d, input bit fl, input bit rd, input bit clr);
    bit w, f, p;
    @(posedge clk);
    #1;
    s_rdy_wr = (m_qcnt < 2) || (m_acc.size() < N - 1);
    s_fl_rdy = (m_qcnt < 2);
    s_rdy_rd = (m_qcnt > 0);
    s_busy   = (m_acc.size() != 0) || (m_qcnt != 0);
    s_valid  = 1'b1;
    clear  = clr;
    en_wr  = wr;
    dat_wr = d;
    fl_en  = fl;
    en_rd  = rd;
    if (clr) begin
      m_acc.delete();
      m_qcnt = 0;
      exp_q_m.delete();
      exp_q_l.delete();
      exp_q_cnt.delete();
    end else begin
      w = wr && s_rdy_wr;
      f = fl && s_fl_rdy;
      p = rd && s_rdy_rd;
      if (w) m_acc.push_back(d);
      if (m_acc.size() == N || (f && m_acc.size() > 0)) begin
        exp_q_m.push_back(pack_words(1'b1));
        exp_q_l.push_back(pack_words(1'b0));
        exp_q_cnt.push_back(CW'(m_acc.size()));
        m_acc.delete();
        m_qcnt++;
      end
      if (p) m_qcnt--;
    end
  endtask

  // monitor: readiness every cycle, head word on every pop
  always @(negedge clk) begin
    if (!rst && s_valid) begin
      chk("rdy_wr_m", {63'd0, rdy_wr_m}, {63'd0, s_rdy_wr});
      chk("rdy_wr_l", {63'd0, rdy_wr_l}, {63'd0, s_rdy_wr});
      chk("fl_rdy", {63'd0, fl_rdy_m}, {63'd0, s_fl_rdy});
      chk("rdy_rd_m", {63'd0, rdy_rd_m}, {63'd0, s_rdy_rd});
      chk("rdy_rd_l", {63'd0, rdy_rd_l}, {63'd0, s_rdy_rd});
      chk("busy", {62'd0, busy_m, busy_l}, {62'd0, s_busy, s_busy});
      if (!clear && en_rd && rdy_rd_m) begin
        if (exp_q_m.size() == 0) begin
          chk("pop_on_empty_model", 64'd1, 64'd0);
        end else begin
          m_last_m   = exp_q_m.pop_front();
          m_last_l   = exp_q_l.pop_front();
          m_last_cnt = exp_q_cnt.pop_front();
          chk("dat_msb", dat_m, m_last_m);
          chk("dat_lsb", dat_l, m_last_l);
          chk("cnt_msb", OW'(cnt_m), OW'(m_last_cnt));
          chk("cnt_lsb", OW'(cnt_l), OW'(m_last_cnt));
        end
      end else if (!s_rdy_rd) begin
        chk("hold_dat_m", dat_m, m_last_m);
        chk("hold_dat_l", dat_l, m_last_l);
        chk("hold_cnt", OW'(cnt_m), OW'(m_last_cnt));
      end
      if (clear) begin
        m_last_m   = '0;
        m_last_l   = '0;
        m_last_cnt = '0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy_wr"}, {62'd0, rdy_wr_m, rdy_wr_l}, 64'd3);
    chk({tag, "_fl_rdy"}, {62'd0, fl_rdy_m, fl_rdy_l}, 64'd3);
    chk({tag, "_rdy_rd"}, {62'd0, rdy_rd_m, rdy_rd_l}, 64'd0);
    chk({tag, "_busy"}, {62'd0, busy_m, busy_l}, 64'd0);
    chk({tag, "_dat_m"}, dat_m, 64'd0);
    chk({tag, "_dat_l"}, dat_l, 64'd0);
    chk({tag, "_cnt"}, {58'd0, cnt_m, cnt_l}, 64'd0);
  endtask

  // asynchronous reset asserted between edges and checked before any edge
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear = 1'b0; en_wr = 1'b0; fl_en = 1'b0; en_rd = 1'b0;
    s_valid = 1'b0;
    m_acc.delete();
    m_qcnt = 0;
    exp_q_m.delete();
    exp_q_l.delete();
    exp_q_cnt.delete();
    m_last_m = '0; m_last_l = '0; m_last_cnt = '0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    step(0, '0, 0, 0, 0);
    check_reset_outputs("post_reset");

    // full word with consumer always ready
    step(1, 16'h0001, 0, 1, 0);
    step(1, 16'h0002, 0, 1, 0);
    step(1, 16'h0003, 0, 1, 0);
    step(1, 16'h0004, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // partial word via lone flush, then flush on empty accumulator
    step(1, 16'hAAAA, 0, 0, 0);
    step(1, 16'hBBBB, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // flush together with the third write, then fresh accumulator
    step(1, 16'h1111, 0, 1, 0);
    step(1, 16'h2222, 0, 1, 0);
    step(1, 16'h3333, 1, 1, 0);
    step(1, 16'h4444, 0, 1, 0);
    step(1, 16'h5555, 1, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);

    // backpressure: fill both entries, keep writing, try to flush, then pop
    for (int i = 0; i < 14; i++) step(1, IW'(16'h0100 + i), (i == 12), 0, 0);
    step(1, 16'h01FF, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 0);

    // clear with two queued words and one pending word
    for (int i = 0; i < 9; i++) step(1, IW'(16'h0200 + i), 0, 0, 0);
    step(1, 16'h02FF, 1, 1, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);

    // random traffic with occasional clears
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), IW'($urandom_range(0, 16'hFFFF)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < ((i / 250) % 2 == 0 ? 3 : 8)),
           ($urandom_range(0, 199) == 0));
    end

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 10; i++) step(1, IW'($urandom_range(0, 16'hFFFF)), 0, 0, 0);
    async_reset();
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, IW'(16'h0300 + i), (i == 5), 1, 0);

    // drain and confirm every expected word was seen
    for (int i = 0; i < 8; i++) step(0, '0, 1, 1, 0);
    step(0, '0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("drained", OW'(exp_q_m.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
